// File: rtl/seg7_pkg.sv
// Shared constants and FSM state type for the seven-segment readback path.
// Segment patterns are active-low, bit0=a ... bit6=g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [3:0] BCD_ERR = 4'hF;

    typedef enum logic [1:0] {
        TRACK,
        DECODE,
        HOLD
    } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern to a BCD digit.
// With blank_ok_i set, the blank pattern is accepted as digit 0.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    input  logic       blank_ok_i,
    output logic [3:0] digit_o,
    output logic       illegal_o
);

    always_comb begin
        digit_o   = BCD_ERR;
        illegal_o = 1'b1;
        if (blank_ok_i && seg_i == SEG_BLANK) begin
            digit_o   = 4'd0;
            illegal_o = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (seg_i == SEG_DIGIT[i]) begin
                digit_o   = 4'(i);
                illegal_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_readback.sv
// Debounces a tens/units segment pair, decodes it to BCD plus binary value
// and hands each new stable reading out over a valid/ready handshake.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [6:0] seg_hi,
    input  logic [6:0] seg_lo,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] bcd_hi,
    output logic [3:0] bcd_lo,
    output logic [4:0] value,
    output logic       err
);

    localparam logic [CNT_W-1:0] NSTB = CNT_W'(STABLE_CYCLES);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       cap_hi_q, cap_hi_d;
    logic [6:0]       cap_lo_q, cap_lo_d;
    logic [6:0]       emit_hi_q, emit_lo_q;
    logic [6:0]       last_hi_q, last_lo_q;
    logic             last_vld_q;
    logic             valid_q, err_q;
    logic [3:0]       bcd_hi_q, bcd_lo_q;
    logic [4:0]       value_q;

    logic [3:0] hi_dig, lo_dig;
    logic       hi_ill, lo_ill, hi_bad;
    logic       err_d, qualify;
    logic [3:0] bcd_hi_d, bcd_lo_d;
    logic [4:0] value_d;

    seg7_to_bcd u_hi (
        .seg_i      (cap_hi_q),
        .blank_ok_i (1'b1),
        .digit_o    (hi_dig),
        .illegal_o  (hi_ill)
    );

    seg7_to_bcd u_lo (
        .seg_i      (cap_lo_q),
        .blank_ok_i (1'b0),
        .digit_o    (lo_dig),
        .illegal_o  (lo_ill)
    );

    // Tens position only ever shows blank or "1".
    assign hi_bad = hi_ill | (cap_hi_q != SEG_BLANK && hi_dig != 4'd1);
    assign err_d  = hi_bad | lo_ill;

    always_comb begin
        bcd_hi_d = err_d ? BCD_ERR : hi_dig;
        bcd_lo_d = err_d ? BCD_ERR : lo_dig;
        value_d  = err_d ? 5'd0 : 5'(hi_dig) * 5'd10 + 5'(lo_dig);
    end

    always_comb begin
        cap_hi_d = cap_hi_q;
        cap_lo_d = cap_lo_q;
        cnt_d    = cnt_q;
        if (sample_en) begin
            if (seg_hi != cap_hi_q || seg_lo != cap_lo_q) begin
                cap_hi_d = seg_hi;
                cap_lo_d = seg_lo;
                cnt_d    = CNT_W'(1);
            end else if (cnt_q != NSTB) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign qualify = (cnt_d == NSTB) &&
                     (!last_vld_q ||
                      cap_hi_d != last_hi_q ||
                      cap_lo_d != last_lo_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TRACK;
            cnt_q      <= '0;
            cap_hi_q   <= SEG_BLANK;
            cap_lo_q   <= SEG_BLANK;
            emit_hi_q  <= SEG_BLANK;
            emit_lo_q  <= SEG_BLANK;
            last_hi_q  <= SEG_BLANK;
            last_lo_q  <= SEG_BLANK;
            last_vld_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            bcd_hi_q   <= 4'd0;
            bcd_lo_q   <= 4'd0;
            value_q    <= 5'd0;
        end else begin
            cnt_q    <= cnt_d;
            cap_hi_q <= cap_hi_d;
            cap_lo_q <= cap_lo_d;
            unique case (state_q)
                TRACK: begin
                    if (qualify) state_q <= DECODE;
                end
                DECODE: begin
                    bcd_hi_q  <= bcd_hi_d;
                    bcd_lo_q  <= bcd_lo_d;
                    value_q   <= value_d;
                    err_q     <= err_d;
                    emit_hi_q <= cap_hi_q;
                    emit_lo_q <= cap_lo_q;
                    valid_q   <= 1'b1;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    // Remember what was delivered, not what is captured now.
                    if (out_ready) begin
                        last_hi_q  <= emit_hi_q;
                        last_lo_q  <= emit_lo_q;
                        last_vld_q <= 1'b1;
                        valid_q    <= 1'b0;
                        state_q    <= TRACK;
                    end
                end
                default: state_q <= TRACK;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign bcd_hi    = bcd_hi_q;
    assign bcd_lo    = bcd_lo_q;
    assign value     = value_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback with STABLE_CYCLES=4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_seg7_readback;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [6:0] seg_hi, seg_lo;
    logic       out_valid, out_ready;
    logic [3:0] bcd_hi, bcd_lo;
    logic [4:0] value;
    logic       err;

    int total  = 0;
    int passed = 0;
    int hits;

    seg7_readback #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .seg_hi    (seg_hi),
        .seg_lo    (seg_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_hi    (bcd_hi),
        .bcd_lo    (bcd_lo),
        .value     (value),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (out_valid) c++;
        end
    endtask

    task automatic chk_result(input string tag, input logic [3:0] h,
                              input logic [3:0] l, input logic [4:0] v,
                              input logic e);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_hi"}, bcd_hi, h);
        chk({tag, "_lo"}, bcd_lo, l);
        chk({tag, "_value"}, value, v);
        chk({tag, "_err"}, err, e);
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        seg_hi    = 7'h7F;
        seg_lo    = 7'h7F;
        out_ready = 1'b0;
        tick(2);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_hi", bcd_hi, 4'd0);
        chk("rst_lo", bcd_lo, 4'd0);
        chk("rst_value", value, 5'd0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        tick(1);

        // "15" with consumer always ready
        seg_hi    = 7'h79;
        seg_lo    = 7'h12;
        sample_en = 1'b1;
        out_ready = 1'b1;
        tick(4);
        chk("t1_early", out_valid, 1'b0);
        tick(1);
        chk_result("t1", 4'd1, 4'd5, 5'd15, 1'b0);
        tick(1);
        chk("t1_pulse", out_valid, 1'b0);

        count_valid(50, hits);
        chk("t2_no_repeat", hits, 0);

        // short glitch back to the same pair must not re-emit
        seg_lo = 7'h40;
        tick(2);
        seg_lo = 7'h12;
        count_valid(20, hits);
        chk("t3_glitch", hits, 0);

        seg_lo = 7'h40;
        tick(4);
        chk("t3_early", out_valid, 1'b0);
        tick(1);
        chk_result("t3", 4'd1, 4'd0, 5'd10, 1'b0);
        tick(1);
        chk("t3_pulse", out_valid, 1'b0);

        // blank units digit is illegal
        seg_hi = 7'h7F;
        seg_lo = 7'h7F;
        tick(5);
        chk_result("t4_blank", 4'hF, 4'hF, 5'd0, 1'b1);
        tick(1);
        seg_lo = 7'h10;
        tick(5);
        chk_result("t4_nine", 4'd0, 4'd9, 5'd9, 1'b0);
        tick(1);
        chk("t4_pulse", out_valid, 1'b0);

        // back-pressure while the input moves on to "19"
        out_ready = 1'b0;
        seg_hi    = 7'h79;
        seg_lo    = 7'h12;
        tick(5);
        chk_result("t5_hold", 4'd1, 4'd5, 5'd15, 1'b0);
        seg_lo = 7'h10;
        hits   = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (!out_valid || value !== 5'd15 || bcd_lo !== 4'd5) hits++;
        end
        chk("t5_stable", hits, 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("t5_acc1", out_valid, 1'b0);
        tick(1);
        chk("t5_acc2", out_valid, 1'b0);
        tick(1);
        chk_result("t5_next", 4'd1, 4'd9, 5'd19, 1'b0);

        // async reset in HOLD, then the same pair re-emits
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 1'b0);
        chk("t6_async_value", value, 5'd0);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(4);
        chk("t6_early", out_valid, 1'b0);
        tick(1);
        chk_result("t6_reemit", 4'd1, 4'd9, 5'd19, 1'b0);
        tick(1);
        chk("t6_pulse", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
